// File: rtl/demorgan_vector_checker_pkg.sv
// Shared types and constants for the De Morgan gate vector checker.
package demorgan_vector_checker_pkg;

    localparam int unsigned VEC_W = 2;

    localparam logic MODE_NAND = 1'b0;
    localparam logic MODE_NOR  = 1'b1;

    localparam logic [VEC_W-1:0] LAST_VEC = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/demorgan_expected_model.sv
// Golden combinational model of the two-input De Morgan gate forms.
module demorgan_expected_model
    import demorgan_vector_checker_pkg::*;
(
    input  logic i_mode,
    input  logic i_a,
    input  logic i_b,
    output logic o_c
);

    always_comb begin
        if (i_mode == MODE_NOR) begin
            o_c = ~i_a & ~i_b;
        end else begin
            o_c = ~i_a | ~i_b;
        end
    end

endmodule

// File: rtl/demorgan_vector_checker.sv
// Steps a/b through 00,01,10,11, holds each vector, and checks the gate output c.
module demorgan_vector_checker
    import demorgan_vector_checker_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic       a_o,
    output logic       b_o,
    input  logic       c_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec
);

    state_e             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [2:0]         r_err;
    logic [VEC_W-1:0]   r_fail;

    state_e             w_state_next;
    logic [VEC_W-1:0]   w_vec_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_mode_next;
    logic [2:0]         w_err_next;
    logic [VEC_W-1:0]   w_fail_next;
    logic               w_expected;
    logic               w_sample;
    logic               w_mismatch;

    demorgan_expected_model u_expected (
        .i_mode (r_mode),
        .i_a    (r_vec[1]),
        .i_b    (r_vec[0]),
        .o_c    (w_expected)
    );

    // c_i is only looked at on the last cycle of each vector's hold window.
    assign w_sample   = (r_state == DRIVE) && (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_mismatch = (c_i != w_expected);

    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        w_cnt_next   = r_cnt;
        w_mode_next  = r_mode;
        w_err_next   = r_err;
        w_fail_next  = r_fail;

        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = DRIVE;
                    w_vec_next   = '0;
                    w_cnt_next   = '0;
                    w_mode_next  = mode;
                    w_err_next   = '0;
                    w_fail_next  = '0;
                end
            end
            DRIVE: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (w_sample) begin
                    if (w_mismatch) begin
                        w_err_next = r_err + 3'd1;
                        if (r_err == 3'd0) begin
                            w_fail_next = r_vec;
                        end
                    end
                    w_cnt_next = '0;
                    if (r_vec == LAST_VEC) begin
                        w_state_next = DONE;
                    end else begin
                        w_vec_next = r_vec + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_next;
            r_vec   <= w_vec_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode_next;
            r_err   <= w_err_next;
            r_fail  <= w_fail_next;
        end
    end

    assign a_o       = r_vec[1];
    assign b_o       = r_vec[0];
    assign busy      = (r_state == DRIVE);
    assign done      = (r_state == DONE);
    assign pass      = done && (r_err == 3'd0);
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_demorgan_vector_checker.sv
// Scoreboard bench: expected vectors/results queued at start, checked as the sweep runs.
module tb_demorgan_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0, mode4 = 1'b0;
    logic       a4, b4, c4, busy4, done4, pass4;
    logic [2:0] err4;
    logic [1:0] fail4;
    int         gate4 = 0;

    logic       start1 = 1'b0, mode1 = 1'b0;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] fail1;
    int         gate1 = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] exp_vec_q[$];
    logic [5:0] exp_res_q[$];   // {pass, err_count, fail_vec}

    always #5 clk = ~clk;

    // 0: correct NAND-form gate, 1: stuck at 1, 2: NOR-form gate
    function automatic logic gate_fn(input int g, input logic a, input logic b);
        case (g)
            0:       return ~(a & b);
            1:       return 1'b1;
            2:       return ~(a | b);
            default: return 1'b0;
        endcase
    endfunction

    assign c4 = gate_fn(gate4, a4, b4);
    assign c1 = gate_fn(gate1, a1, b1);

    demorgan_vector_checker #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .mode      (mode4),
        .a_o       (a4),
        .b_o       (b4),
        .c_i       (c4),
        .busy      (busy4),
        .done      (done4),
        .pass      (pass4),
        .err_count (err4),
        .fail_vec  (fail4)
    );

    demorgan_vector_checker #(.HOLD_CYCLES(1), .CNT_W(2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .mode      (mode1),
        .a_o       (a1),
        .b_o       (b1),
        .c_i       (c1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_vec  (fail1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the per-cycle vector sequence and the final result the sweep should produce.
    task automatic push_expected(input int g, input logic m, input int hold);
        logic [2:0] err;
        logic [1:0] fv;
        logic [1:0] v;
        logic       want;
        err = 3'd0;
        fv  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            want = m ? ~(v[1] | v[0]) : ~(v[1] & v[0]);
            for (int h = 0; h < hold; h++) exp_vec_q.push_back(v);
            if (gate_fn(g, v[1], v[0]) != want) begin
                if (err == 3'd0) fv = v;
                err = err + 3'd1;
            end
        end
        exp_res_q.push_back({(err == 3'd0), err, fv});
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({a4, b4, busy4, done4, pass4, err4, fail4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut4: got %b required 0000000000",
                     {a4, b4, busy4, done4, pass4, err4, fail4});
        end
        n_cmp++;
        if ({a1, b1, busy1, done1, pass1, err1, fail1} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %b required 0000000000",
                     {a1, b1, busy1, done1, pass1, err1, fail1});
        end
    endtask

    // Full sweep on the HOLD_CYCLES=4 instance; optionally re-pulse start mid-sweep.
    task automatic run_sweep4(input string name, input int g, input logic m, input int pulse_at);
        logic [1:0] ev;
        logic [5:0] er;
        int         n;
        gate4 = g;
        mode4 = m;
        push_expected(g, m, 4);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        mode4  = ~m;   // mode must have been captured at start
        n = 0;
        while (exp_vec_q.size() > 0) begin
            ev = exp_vec_q.pop_front();
            n_cmp++;
            if ({a4, b4, busy4, done4} !== {ev, 2'b10}) begin
                n_fail++;
                $display("FAIL %s_vec cyc%0d: got ab=%b busy=%b done=%b required ab=%b busy=1 done=0",
                         name, n, {a4, b4}, busy4, done4, ev);
            end
            if (n == 0) begin
                n_cmp++;
                if ({pass4, err4, fail4} !== 6'd0) begin
                    n_fail++;
                    $display("FAIL %s_clear: got pass/err/fail=%b required 000000",
                             name, {pass4, err4, fail4});
                end
            end
            start4 = (n == pulse_at);
            step();
            n++;
        end
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 8) begin
            step();
            n++;
        end
        er = exp_res_q.pop_front();
        n_cmp++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL %s_done_latency: got %0d extra cycles required 0", name, n);
        end
        n_cmp++;
        if ({pass4, err4, fail4, busy4, a4, b4} !== {er, 3'b011}) begin
            n_fail++;
            $display("FAIL %s_result: got pass=%b err=%0d fail=%b busy=%b ab=%b required pass=%b err=%0d fail=%b busy=0 ab=11",
                     name, pass4, err4, fail4, busy4, {a4, b4}, er[5], er[4:2], er[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        gate4  = 0;
        mode4  = 1'b0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (9) step();
        n_cmp++;
        if ({a4, b4} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got ab=%b required 10", {a4, b4});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a4, b4, busy4, done4, pass4, err4, fail4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b required 0000000000",
                     {a4, b4, busy4, done4, pass4, err4, fail4});
        end
        step();
        rst_n = 1'b1;
        repeat (6) step();
        n_cmp++;
        if ({a4, b4, busy4, done4, pass4, err4, fail4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %b required 0000000000",
                     {a4, b4, busy4, done4, pass4, err4, fail4});
        end
    endtask

    task automatic test_hold1();
        logic [1:0] ev;
        logic [5:0] er;
        int         n;
        gate1 = 0;
        mode1 = 1'b0;
        push_expected(0, 1'b0, 1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 0;
        while (exp_vec_q.size() > 0) begin
            ev = exp_vec_q.pop_front();
            n_cmp++;
            if ({a1, b1, busy1} !== {ev, 1'b1}) begin
                n_fail++;
                $display("FAIL hold1_vec cyc%0d: got ab=%b busy=%b required ab=%b busy=1",
                         n, {a1, b1}, busy1, ev);
            end
            step();
            n++;
        end
        er = exp_res_q.pop_front();
        n_cmp++;
        if ({done1, pass1, err1, fail1} !== {1'b1, er}) begin
            n_fail++;
            $display("FAIL hold1_result: got done=%b pass=%b err=%0d fail=%b required done=1 pass=%b err=%0d fail=%b",
                     done1, pass1, err1, fail1, er[5], er[4:2], er[1:0]);
        end
    endtask

    initial begin
        #1;
        test_reset();
        #20;
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        run_sweep4("nand_pass", 0, 1'b0, -1);
        run_sweep4("stuck_high", 1, 1'b0, -1);
        run_sweep4("restart_ignore", 0, 1'b0, 5);
        run_sweep4("nor_on_nand", 0, 1'b1, -1);
        run_sweep4("nor_pass", 2, 1'b1, 15);
        test_reset_mid();
        test_hold1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
